memory_access_master: RTL and testbench

- Initiator side of the segmented memory write and read ports.
- Accepts a burst command (direction, start address, beat count) on a valid/ready command port.
- Writes: feeds write beats from a write-data stream onto the memory write port. Reads: issues reads on the memory read port and returns the data on a response stream with backpressure.
- Sits between a DMA/test sequencer and memory_controller/ram. One burst outstanding at a time.

---
 rtl/memory_access_master.sv | 150 +++++++++++++++
 tb/tb_memory_access_master.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_master.sv
// Burst initiator for the segmented memory write/read ports: takes one burst
// command at a time, streams write beats out or read beats back with backpressure.
module memory_access_master #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 8,
  parameter int ADDR_STEP    = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              done,
  output logic [ADDR_W-1:0] wr_address,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_enable,
  output logic [ADDR_W-1:0] rd_address,
  output logic              rd_enable,
  input  logic [DATA_W-1:0] rd_data
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_REQ,
    READ_WAIT,
    READ_RESP
  } state_t;

  localparam int                LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(READ_LATENCY - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;
  logic [LAT_W-1:0]  lat_cnt;
  // Low in reset and until the first edge after release, so cmd_ready stays 0 there.
  logic              active;

  always_comb begin
    cmd_ready   = active && (state == IDLE);
    wdata_ready = (state == WRITE);
  end

  // NOTE: every register here is assigned with <= so all branches see the
  // pre-edge values of cur_addr/remaining regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      active     <= 1'b0;
      cur_addr   <= '0;
      remaining  <= '0;
      lat_cnt    <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_last   <= 1'b0;
      done       <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
      wr_enable  <= 1'b0;
      rd_address <= '0;
      rd_enable  <= 1'b0;
    end else begin
      active    <= 1'b1;
      wr_enable <= 1'b0;
      rd_enable <= 1'b0;
      done      <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cur_addr  <= cmd_address;
            remaining <= cmd_len;
            if (cmd_write) begin
              state <= WRITE;
            end else begin
              // Strobe is registered, so it is launched on entry to READ_REQ.
              state      <= READ_REQ;
              rd_enable  <= 1'b1;
              rd_address <= cmd_address;
            end
          end
        end

        WRITE: begin
          if (wdata_valid) begin
            wr_enable  <= 1'b1;
            wr_address <= cur_addr;
            wr_data    <= wdata;
            cur_addr   <= cur_addr + STEP;
            if (remaining == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              remaining <= remaining - 1'b1;
            end
          end
        end

        READ_REQ: begin
          state   <= READ_WAIT;
          lat_cnt <= LAT_LOAD;
        end

        READ_WAIT: begin
          if (lat_cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rd_data;
            rsp_last  <= (remaining == '0);
            state     <= READ_RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        READ_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            if (rsp_last) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              cur_addr   <= cur_addr + STEP;
              remaining  <= remaining - 1'b1;
              rd_enable  <= 1'b1;
              rd_address <= cur_addr + STEP;
              state      <= READ_REQ;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_master.sv
// Directed bench for memory_access_master: write bursts with gaps, read burst
// with backpressure, address wrap, busy command hold and reset mid-read.
module tb_memory_access_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_address;
  logic [7:0]  cmd_len;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic        rsp_valid, rsp_ready, rsp_last, done;
  logic [31:0] rsp_data;
  logic [31:0] wr_address, wr_data, rd_address, rd_data;
  logic        wr_enable, rd_enable;

  int n_total = 0;
  int n_pass  = 0;

  memory_access_master dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_address (cmd_address),
    .cmd_len     (cmd_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_last    (rsp_last),
    .done        (done),
    .wr_address  (wr_address),
    .wr_data     (wr_data),
    .wr_enable   (wr_enable),
    .rd_address  (rd_address),
    .rd_enable   (rd_enable),
    .rd_data     (rd_data)
  );

  always #5 clock = ~clock;

  // Two-stage memory read pipeline: data for an address appears exactly two
  // cycles after its rd_enable cycle; any other cycle shows a poison pattern.
  logic [31:0] mem_stage;
  always @(posedge clock) begin
    mem_stage <= rd_enable ? (rd_address ^ 32'h0000_A5A5) : 32'hBAD0_0000;
    rd_data   <= mem_stage;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    cmd_valid   = 1'b1;
    cmd_write   = wr;
    cmd_address = addr;
    cmd_len     = len;
    step();
    cmd_valid = 1'b0;
  endtask

  logic        gap_v   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [31:0] gap_addr[4] = '{32'h200, 32'h204, 32'h208, 32'h20C};
  logic [31:0] rd_exp  [3] = '{32'h0000_A5E5, 32'h0000_A5E1, 32'h0000_A5ED};
  logic [31:0] rd_addr [3] = '{32'h40, 32'h44, 32'h48};

  initial begin
    int beat;
    reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_address = '0;
    cmd_len     = '0;
    wdata_valid = 1'b0;
    wdata       = '0;
    rsp_ready   = 1'b0;

    // Reset state
    step();
    step();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_strobes", {28'd0, wr_enable, rd_enable, rsp_valid, done}, 32'd0);
    check("rst_wr_addr", wr_address, 32'd0);
    reset = 1'b1;
    step();
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Single write
    send_cmd(1'b1, 32'h100, 8'd0);
    check("w1_wdata_ready", {31'd0, wdata_ready}, 32'd1);
    check("w1_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    wdata_valid = 1'b1;
    wdata       = 32'hDEAD_BEEF;
    step();
    wdata_valid = 1'b0;
    check("w1_wr_enable", {31'd0, wr_enable}, 32'd1);
    check("w1_wr_address", wr_address, 32'h100);
    check("w1_wr_data", wr_data, 32'hDEAD_BEEF);
    check("w1_done", {31'd0, done}, 32'd1);
    check("w1_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    check("w1_strobe_off", {30'd0, wr_enable, done}, 32'd0);

    // Write burst with gaps
    send_cmd(1'b1, 32'h200, 8'd3);
    beat = 0;
    for (int i = 0; i < 6; i++) begin
      wdata_valid = gap_v[i];
      wdata       = gap_v[i] ? 32'(beat + 1) : 32'hFFFF_FFFF;
      step();
      check($sformatf("gap_wr_enable_%0d", i), {31'd0, wr_enable}, {31'd0, gap_v[i]});
      check($sformatf("gap_done_%0d", i), {31'd0, done}, (i == 5) ? 32'd1 : 32'd0);
      if (gap_v[i]) begin
        check($sformatf("gap_wr_address_%0d", beat), wr_address, gap_addr[beat]);
        check($sformatf("gap_wr_data_%0d", beat), wr_data, 32'(beat + 1));
        beat++;
      end
    end
    wdata_valid = 1'b0;

    // Read burst with backpressure on the first beat
    step();
    send_cmd(1'b0, 32'h40, 8'd2);
    for (int b = 0; b < 3; b++) begin
      check($sformatf("rd_enable_%0d", b), {31'd0, rd_enable}, 32'd1);
      check($sformatf("rd_address_%0d", b), rd_address, rd_addr[b]);
      check($sformatf("rd_no_wr_%0d", b), {31'd0, wr_enable}, 32'd0);
      step();
      check($sformatf("rd_wait1_%0d", b), {30'd0, rd_enable, rsp_valid}, 32'd0);
      step();
      check($sformatf("rd_wait2_%0d", b), {31'd0, rsp_valid}, 32'd0);
      step();
      check($sformatf("rsp_valid_%0d", b), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("rsp_data_%0d", b), rsp_data, rd_exp[b]);
      check($sformatf("rsp_last_%0d", b), {31'd0, rsp_last}, (b == 2) ? 32'd1 : 32'd0);
      for (int s = 0; s < ((b == 0) ? 3 : 0); s++) begin
        step();
        check($sformatf("stall_valid_%0d", s), {31'd0, rsp_valid}, 32'd1);
        check($sformatf("stall_data_%0d", s), rsp_data, rd_exp[b]);
        check($sformatf("stall_last_%0d", s), {31'd0, rsp_last}, 32'd0);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check($sformatf("rsp_taken_%0d", b), {31'd0, rsp_valid}, 32'd0);
      check($sformatf("rd_done_%0d", b), {31'd0, done}, (b == 2) ? 32'd1 : 32'd0);
    end
    check("rd_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    check("rd_done_pulse_end", {31'd0, done}, 32'd0);

    // Address wrap
    send_cmd(1'b1, 32'hFFFF_FFFC, 8'd1);
    wdata_valid = 1'b1;
    wdata       = 32'hA;
    step();
    check("wrap_addr0", wr_address, 32'hFFFF_FFFC);
    wdata = 32'hB;
    step();
    wdata_valid = 1'b0;
    check("wrap_addr1", wr_address, 32'h0000_0000);
    check("wrap_data1", wr_data, 32'hB);
    check("wrap_done", {31'd0, done}, 32'd1);

    // Command held while busy
    step();
    send_cmd(1'b1, 32'h300, 8'd1);
    cmd_valid   = 1'b1;
    cmd_address = 32'h400;
    cmd_len     = 8'd0;
    check("busy_cmd_ready0", {31'd0, cmd_ready}, 32'd0);
    wdata_valid = 1'b1;
    wdata       = 32'h11;
    step();
    check("busy_cmd_ready1", {31'd0, cmd_ready}, 32'd0);
    check("busy_wr_addr0", wr_address, 32'h300);
    wdata = 32'h22;
    step();
    wdata_valid = 1'b0;
    check("busy_done", {31'd0, done}, 32'd1);
    check("busy_cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    check("queued_accepted", {31'd0, wdata_ready}, 32'd1);
    check("queued_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    wdata_valid = 1'b1;
    wdata       = 32'h33;
    step();
    wdata_valid = 1'b0;
    check("queued_wr_addr", wr_address, 32'h400);
    check("queued_wr_data", wr_data, 32'h33);
    check("queued_done", {31'd0, done}, 32'd1);

    // Reset during READ_WAIT
    step();
    send_cmd(1'b0, 32'h80, 8'd0);
    check("rst_rd_enable_pre", {31'd0, rd_enable}, 32'd1);
    step();
    reset = 1'b0;
    #1;
    check("midrst_strobes", {27'd0, cmd_ready, wr_enable, rd_enable, rsp_valid, done}, 32'd0);
    check("midrst_rd_address", rd_address, 32'd0);
    step();
    step();
    step();
    check("midrst_no_done", {30'd0, rsp_valid, done}, 32'd0);
    reset = 1'b1;
    step();
    check("after_rst_no_done", {31'd0, done}, 32'd0);
    check("after_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    send_cmd(1'b0, 32'h10, 8'd0);
    check("rd2_rd_address", rd_address, 32'h10);
    step();
    step();
    step();
    check("rd2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd2_rsp_data", rsp_data, 32'h0000_A5B5);
    check("rd2_rsp_last", {31'd0, rsp_last}, 32'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rd2_done", {31'd0, done}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
